// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed restoring sequential divider, one quotient bit per cycle.
// Optional macro SEQ_DIVIDER_DIVZERO_CHECK_EN: zero divisor takes a one-cycle short path with divzero flag.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remain,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qd_q, qd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             nsign_q, nsign_d;
  logic             qneg_q, qneg_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;

  logic [WIDTH-1:0] numer_mag, denom_mag;
  logic [WIDTH:0]   shifted, diff;

  // Most negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
  assign numer_mag = numer[WIDTH-1] ? -numer : numer;
  assign denom_mag = denom[WIDTH-1] ? -denom : denom;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
  assign shifted = {rem_q, qd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

`ifdef SEQ_DIVIDER_DIVZERO_CHECK_EN
  logic dz_q, dz_d;
  assign divzero = dz_q;
`else
  assign divzero = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign quotient = quot_q;
  assign remain   = remo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qd_d    = qd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    nsign_d = nsign_q;
    qneg_d  = qneg_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
`ifdef SEQ_DIVIDER_DIVZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SEQ_DIVIDER_DIVZERO_CHECK_EN
          if (denom == '0) begin
            quot_d = '0;
            remo_d = numer;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else
`endif
          begin
            state_d = BUSY;
            cnt_d   = '0;
            qd_d    = numer_mag;
            rem_d   = '0;
            dvs_d   = denom_mag;
            nsign_d = numer[WIDTH-1];
            qneg_d  = numer[WIDTH-1] ^ denom[WIDTH-1];
          end
        end
      end
      BUSY: begin
        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        qd_d  = {qd_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d  = qneg_q ? -qd_q : qd_q;
        remo_d  = nsign_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SEQ_DIVIDER_DIVZERO_CHECK_EN
        dz_d    = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qd_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      nsign_q <= 1'b0;
      qneg_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
`ifdef SEQ_DIVIDER_DIVZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qd_q    <= qd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      nsign_q <= nsign_d;
      qneg_q  <= qneg_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
`ifdef SEQ_DIVIDER_DIVZERO_CHECK_EN
      dz_q    <= dz_d;
`endif
    end
  end

endmodule
